// File: rtl/pcm_to_i2s.sv
// rtl/pcm_to_i2s.sv - stereo PCM stream to Philips I2S transmitter
//
// Accepts {left, right} PCM frames on a stream slave port and serialises them
// as standard I2S (one-bit delay after lrclk, MSB first, zero padded).
// bclk is derived from clk by a clock-enable divider, so everything runs in
// the clk domain.
//
// Parameters:
//   WIDTH   - sample width per channel (1 <= WIDTH <= BITS-1)
//   BITS    - bclk periods per channel slot
//   CLK_DIV - clk cycles per bclk half-period (>= 1)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   s_tdata     in   {left, right} two's complement frame
//   s_tvalid    in   frame valid
//   s_tready    out  holding register empty
//   bclk        out  I2S bit clock
//   lrclk       out  word select (0 = left, 1 = right)
//   sdata       out  serial data
//   frame_start out  one-cycle pulse when a frame is loaded for playback
//   underrun    out  one-cycle pulse when a frame slot starts with no frame
//
// Build option:
//   I2S_TX_UNDERRUN_HOLD_EN - when defined, an underrun repeats the last
//   frame; otherwise silence is sent.

module pcm_to_i2s #(
   parameter int WIDTH   = 16,
   parameter int BITS    = 32,
   parameter int CLK_DIV = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*WIDTH-1:0]   s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic                 bclk,
   output logic                 lrclk,
   output logic                 sdata,
   output logic                 frame_start,
   output logic                 underrun
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(2 * BITS);

   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(2 * BITS - 1);
   localparam logic [BW-1:0] SLOT_BITS = BW'(BITS);

   logic [DW-1:0]        div_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [BW-1:0]        bit_nxt;
   logic [BW-1:0]        slot;
   logic [2*WIDTH-1:0]   hold;
   logic [2*WIDTH-1:0]   frame;
   logic                 hold_full;
   logic [WIDTH-1:0]     word;
   logic                 tick;
   logic                 fe;
   logic                 lr_nxt;
   logic                 sd_nxt;

   assign s_tready = !hold_full;
   assign tick     = (div_cnt == DIV_LAST);
   // A toggle while bclk is high is the falling edge that advances the bit.
   assign fe       = tick && bclk;

   // Everything here is evaluated for the bit position being entered, so
   // lrclk and sdata update together with the bclk fall.
   always_comb begin
      bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      lr_nxt  = (bit_nxt >= SLOT_BITS);
      slot    = lr_nxt ? (bit_nxt - SLOT_BITS) : bit_nxt;
      word    = lr_nxt ? frame[WIDTH-1:0] : frame[2*WIDTH-1:WIDTH];
      // Slot position s carries word[WIDTH-s] for 1 <= s <= WIDTH; slot 0 is
      // the I2S one-bit delay and positions past the LSB are padding.
      sd_nxt  = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (slot == BW'(WIDTH - i)) begin
            sd_nxt = word[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         bclk        <= 1'b0;
         lrclk       <= 1'b0;
         sdata       <= 1'b0;
         bit_cnt     <= BIT_LAST;
         hold        <= '0;
         hold_full   <= 1'b0;
         frame       <= '0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         underrun    <= 1'b0;

         // Load (below) only fires with hold_full set, so it never collides
         // with a handshake in the same cycle.
         if (s_tvalid && !hold_full) begin
            hold      <= s_tdata;
            hold_full <= 1'b1;
         end

         if (tick) begin
            div_cnt <= '0;
            bclk    <= !bclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (fe) begin
            bit_cnt <= bit_nxt;
            lrclk   <= lr_nxt;
            sdata   <= sd_nxt;
            if (bit_nxt == '0) begin
               if (hold_full) begin
                  frame       <= hold;
                  hold_full   <= 1'b0;
                  frame_start <= 1'b1;
               end else begin
                  underrun <= 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                  frame    <= frame;
`else
                  frame    <= '0;
`endif
               end
            end
         end
      end
   end

endmodule
